// File: rtl/onehot_pkg.sv
// onehot_pkg: shared types and helpers for the one-hot pulse decoder.
// Used by onehot_pulse_decoder (optional skid buffer: ONEHOT_DEC_SKID_EN).
package onehot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_t;

  localparam int OH_MAX = 256;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

  function automatic logic [OH_MAX-1:0] onehot_of(
    input int idx,
    input int n
  );
    logic [OH_MAX-1:0] r;
    r = '0;
    if (idx >= 0 && idx < n && idx < OH_MAX) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/onehot_pulse_decoder_timer.sv
// onehot_pulse_timer: loadable down-counter with zero flag.
// Shared by the DRIVE and GAP windows of the decoder.
module onehot_pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // count register: load has priority over decrement
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: binary index in, timed one-hot pulse out.
// Define ONEHOT_DEC_SKID_EN to add a one-entry skid register.
module onehot_pulse_decoder
  import onehot_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int OUT_W     = 8,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_valid,
  output logic             sel_ready,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] a,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W =
    clog2(max3(PULSE_CYC, GAP_CYC, 2));
  localparam logic [CNT_W-1:0] PULSE_LD =
    CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD =
    CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t state, state_n;

  logic [SEL_W-1:0]  sel_q, sel_n;
  logic [CNT_W-1:0]  cnt, load_val;
  logic              zero, load, dec;
  logic              win_end, xfer;
  logic              ready_raw, pend;
  logic [SEL_W-1:0]  pend_sel;
  logic [OH_MAX-1:0] oh_full;
  logic              unused_oh;
  logic [OUT_W-1:0]  a_n;

  assign sel_ready = !rst && ready_raw;
  assign xfer      = sel_valid && sel_ready;

  onehot_pulse_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .cnt      (cnt),
    .zero     (zero)
  );

`ifdef ONEHOT_DEC_SKID_EN
  logic             skid_full;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_push, skid_pop;

  assign ready_raw = !skid_full;
  // an index arriving on the closing edge of an empty-skid
  // window is handed straight to DRIVE instead of parking
  assign pend      = skid_full || (xfer && state != IDLE);
  assign pend_sel  = skid_full ? skid_sel : sel;
  assign skid_push = xfer && state != IDLE && !win_end;
  assign skid_pop  = win_end && skid_full;

  // skid register holds one index accepted mid-window
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_full <= 1'b0;
      skid_sel  <= '0;
    end else if (skid_push) begin
      skid_full <= 1'b1;
      skid_sel  <= sel;
    end else if (skid_pop) begin
      skid_full <= 1'b0;
    end
  end
`else
  assign ready_raw = (state == IDLE);
  assign pend      = 1'b0;
  assign pend_sel  = sel_q;
`endif

  // next-state, latched index and timer control
  always_comb begin
    state_n  = state;
    sel_n    = sel_q;
    load     = 1'b0;
    load_val = PULSE_LD;
    dec      = 1'b0;
    win_end  = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          state_n = DRIVE;
          sel_n   = sel;
          load    = 1'b1;
        end
      end
      DRIVE: begin
        if (!zero) begin
          dec = 1'b1;
        end else if (GAP_CYC > 0) begin
          state_n  = GAP;
          load     = 1'b1;
          load_val = GAP_LD;
        end else begin
          win_end = 1'b1;
        end
      end
      GAP: begin
        if (!zero) dec = 1'b1;
        else win_end = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (win_end) begin
      if (pend) begin
        state_n  = DRIVE;
        sel_n    = pend_sel;
        load     = 1'b1;
        load_val = PULSE_LD;
      end else begin
        state_n = IDLE;
      end
    end
  end

  assign oh_full   = onehot_of(int'(sel_n), OUT_W);
  assign unused_oh = ^oh_full;
  assign a_n = (state_n == DRIVE) ? oh_full[OUT_W-1:0] : '0;

  // state, latched index and registered one-hot output
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
      a     <= '0;
    end else begin
      state <= state_n;
      sel_q <= sel_n;
      a     <= a_n;
    end
  end

  assign busy = (state != IDLE);
  assign done = !rst && state == DRIVE && zero;
  assign err  = !rst && state == DRIVE &&
                cnt == PULSE_LD &&
                int'(sel_q) >= OUT_W;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb_onehot_pulse_decoder: scoreboard bench over three configurations.
// d0 default, d1 OUT_W=6, d2 PULSE_CYC=1/GAP_CYC=0.
module tb_onehot_pulse_decoder;

`ifdef ONEHOT_DEC_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int SPACE = SKID ? 5 : 6;

  typedef struct {
    int         t;
    int         plen;
    logic [7:0] a;
    bit         err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 0, v1 = 0, v2 = 0;
  logic [2:0] s0 = 0, s1 = 0, s2 = 0;
  logic       r0, r1, r2;
  logic [7:0] a0, a2;
  logic [5:0] a1;
  logic       b0, b1, b2, dn0, dn1, dn2, e0, e1, e2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q [3][$];
  int   dt0[$];
  int   run [3];
  bit   seen [3];

  logic [7:0] a_o [3];
  logic [2:0] done_o, err_o, busy_o, rdy_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  onehot_pulse_decoder d0 (
    .clk(clk), .rst(rst), .sel_valid(v0), .sel_ready(r0),
    .sel(s0), .a(a0), .busy(b0), .done(dn0), .err(e0)
  );

  onehot_pulse_decoder #(.OUT_W(6)) d1 (
    .clk(clk), .rst(rst), .sel_valid(v1), .sel_ready(r1),
    .sel(s1), .a(a1), .busy(b1), .done(dn1), .err(e1)
  );

  onehot_pulse_decoder #(.PULSE_CYC(1), .GAP_CYC(0)) d2 (
    .clk(clk), .rst(rst), .sel_valid(v2), .sel_ready(r2),
    .sel(s2), .a(a2), .busy(b2), .done(dn2), .err(e2)
  );

  always_comb begin
    a_o[0] = a0;
    a_o[1] = {2'b00, a1};
    a_o[2] = a2;
    done_o = {dn2, dn1, dn0};
    err_o  = {e2, e1, e0};
    busy_o = {b2, b1, b0};
    rdy_o  = {r2, r1, r0};
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input int idx);
    case (d)
      0: begin v0 = v; s0 = 3'(idx); end
      1: begin v1 = v; s1 = 3'(idx); end
      default: begin v2 = v; s2 = 3'(idx); end
    endcase
  endtask

  // called at a negedge; returns at the negedge after the transfer
  task automatic send(input int d, input int idx);
    exp_t e;
    int   n;
    int   ow;
    set_in(d, 1'b1, idx);
    n = 0;
    while (!rdy_o[d] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(rdy_o[d]), 1);
    if (!rdy_o[d]) begin
      set_in(d, 1'b0, 0);
      return;
    end
    ow     = (d == 1) ? 6 : 8;
    e.a    = (idx < ow) ? 8'(1 << idx) : 8'h00;
    e.err  = (idx >= ow);
    e.plen = (d == 2) ? 1 : 4;
    e.t    = busy_o[d] ? -1 : cyc;
    q[d].push_back(e);
    @(posedge clk);
    @(negedge clk);
    set_in(d, 1'b0, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 ||
            q[2].size() != 0 || busy_o != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 200), 1);
  endtask

  // monitor: compares every presented output against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        q[d].delete();
        run[d]  = 0;
        seen[d] = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (a_o[d] != 0) begin
          chk("onehot", 32'($onehot(a_o[d])), 1);
          if (q[d].size() == 0)
            chk("a_unexpected", q[d].size(), 1);
          else
            chk("a_value", a_o[d], q[d][0].a);
          run[d]++;
        end
        if (err_o[d]) begin
          if (q[d].size() == 0) begin
            chk("err_unexpected", q[d].size(), 1);
          end else begin
            chk("err_flag", 32'(q[d][0].err), 1);
            if (q[d][0].t >= 0)
              chk("err_lat", cyc - q[d][0].t, 1);
          end
          seen[d] = 1'b1;
        end
        if (done_o[d]) begin
          if (q[d].size() == 0) begin
            chk("done_unexpected", q[d].size(), 1);
          end else begin
            e = q[d].pop_front();
            chk("done_a", a_o[d], e.a);
            chk("err_seen", 32'(seen[d]), 32'(e.err));
            if (e.t >= 0) chk("done_lat", cyc - e.t, e.plen);
            if (e.a != 0) chk("pulse_len", run[d], e.plen);
            if (d == 0) dt0.push_back(cyc);
          end
          run[d]  = 0;
          seen[d] = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 32'(r0), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a", 32'(a0), 0);
    chk("rst_busy", 32'(b0), 0);
    chk("rst_done", 32'(dn0), 0);
    chk("rst_err", 32'(e0), 0);
    chk("rst_ready", 32'(r0), 1);

    // single transfer sel=5
    send(0, 5);
    chk("sel5_a_first", 32'(a0), 32'h20);
    repeat (4) @(negedge clk);
    chk("sel5_gap_a", 32'(a0), 0);
    chk("sel5_gap_ready", 32'(r0), 32'(SKID));
    @(negedge clk);
    chk("sel5_ready_back", 32'(r0), 1);
    wait_idle();

    // sweep 0..7 with valid held high
    dt0.delete();
    for (int i = 0; i < 8; i++) send(0, i);
    wait_idle();
    chk("sweep_count", dt0.size(), 8);
    for (int i = 1; i < dt0.size(); i++)
      chk("sweep_space", dt0[i] - dt0[i-1], SPACE);

    // out-of-range and in-range on OUT_W=6
    send(1, 7);
    chk("oor_a", 32'(a1), 0);
    wait_idle();
    send(1, 2);
    wait_idle();

    // reset in the second DRIVE cycle
    send(0, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_a", 32'(a0), 0);
    chk("abort_busy", 32'(b0), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 4);
    wait_idle();

    // single-cycle pulse with no gap
    send(2, 2);
    chk("short_a", 32'(a2), 32'h04);
    @(negedge clk);
    chk("short_after", 32'(a2), 0);
    wait_idle();

`ifdef ONEHOT_DEC_SKID_EN
    dt0.delete();
    send(0, 1);
    send(0, 6);
    set_in(0, 1'b1, 2);
    chk("skid_full_ready", 32'(r0), 0);
    set_in(0, 1'b0, 0);
    wait_idle();
    chk("skid_count", dt0.size(), 2);
    if (dt0.size() == 2)
      chk("skid_space", dt0[1] - dt0[0], 5);
`endif

    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
